// File: rtl/wb_serializer_sched_pkg.sv
// rtl/wb_serializer_sched_pkg.sv - shared types, register map and bit indices for wb_serializer_sched
package WBSerSched;

    // Register addresses, decoded from ADR_I[2:0]
    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_TXDATA = 3'd1;
    localparam logic [2:0] ADR_STATUS = 3'd2;
    localparam logic [2:0] ADR_IDLE   = 3'd3;
    localparam logic [2:0] ADR_TXCNT  = 3'd4;
    localparam logic [2:0] ADR_CLR    = 3'd5;

    // CTRL bit indices
    localparam int CTRL_EN         = 0;
    localparam int CTRL_IDLE_FILL  = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_FLUSH      = 3;
    localparam int CTRL_LOW_WM_LSB = 8;

    // STATUS bit indices (also used by CLR for the sticky bits)
    localparam int ST_BUSY      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_UNR       = 4;
    localparam int ST_LEVEL_LSB = 16;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} sched_state_t;

    typedef logic [26:0] frame_t;

    // Three K28.5 commas
    localparam frame_t IDLE_DEFAULT = {3{9'h1BC}};

endpackage

// File: rtl/wb_serializer_sched_if.sv
// rtl/wb_serializer_sched_if.sv - Wishbone slave bus bundle for wb_serializer_sched
// Ports: CYC_I/STB_I/WE_I/ADR_I/DAT_I driven by the master; ACK_O/ERR_O/DAT_O driven by the slave.
interface wb_serializer_sched_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output ACK_O, ERR_O, DAT_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  ACK_O, ERR_O, DAT_O
    );
endinterface

// File: rtl/wb_ser_fifo.sv
// rtl/wb_ser_fifo.sv - synchronous frame FIFO with flush and level
// Ports: clk/rst (sync active-high); push/wr_data, pop/rd_data (show-ahead), flush; full, empty, level.
module wb_ser_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [26:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              wr_data,
    input  logic          pop,
    output T              rd_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/wb_serializer_sched.sv
// rtl/wb_serializer_sched.sv - Wishbone-programmed frame scheduler feeding one serializer
// Ports: CLK_I, RST_I (sync active-high); wb (Wishbone slave, combinational ACK/ERR/DAT_O);
//        ser_start_o/ser_data_o/ser_done_i serializer handshake; irq_o low-watermark level.
module wb_serializer_sched
    import WBSerSched::*;
#(
    parameter int     FIFO_DEPTH = 8,
    parameter frame_t IDLE_RST   = IDLE_DEFAULT
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    wb_serializer_sched_if.slave   wb,
    output logic                   ser_start_o,
    output frame_t                 ser_data_o,
    input  logic                   ser_done_i,
    output logic                   irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        req, map_ok, wr, rd;
    logic [2:0]  adr;
    logic [31:0] rdata;
    logic        unused_bits;

    // Registers
    logic         enable_q, enable_d;
    logic         idle_fill_q, idle_fill_d;
    logic         irq_en_q, irq_en_d;
    logic [7:0]   low_wm_q, low_wm_d;
    frame_t       idle_q, idle_d;
    logic [31:0]  txcnt_q, txcnt_d;
    logic         ovf_q, ovf_d;
    logic         unr_q, unr_d;

    // FIFO and scheduler
    logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    frame_t        fifo_rd;
    sched_state_t  state_q;
    frame_t        frame_q;
    logic          is_data_q, start_q;
    logic          load_idle, underrun_evt, done_cnt;

    assign adr         = wb.ADR_I[2:0];
    assign req         = wb.CYC_I && wb.STB_I;
    assign unused_bits = ^{wb.ADR_I[31:3], wb.DAT_I[31:27]};

    always_comb begin
        map_ok = 1'b0;
        case (adr)
            ADR_CTRL, ADR_IDLE, ADR_TXCNT: map_ok = 1'b1;
            ADR_TXDATA, ADR_CLR:           map_ok = wb.WE_I;
            ADR_STATUS:                    map_ok = !wb.WE_I;
            default:                       map_ok = 1'b0;
        endcase
    end

    assign wb.ACK_O = req && map_ok;
    assign wb.ERR_O = req && !map_ok;
    assign wr = wb.ACK_O && wb.WE_I;
    assign rd = wb.ACK_O && !wb.WE_I;

    always_comb begin
        rdata = '0;
        case (adr)
            ADR_CTRL: begin
                rdata[CTRL_EN]        = enable_q;
                rdata[CTRL_IDLE_FILL] = idle_fill_q;
                rdata[CTRL_IRQ_EN]    = irq_en_q;
                rdata[CTRL_LOW_WM_LSB +: 8] = low_wm_q;
            end
            ADR_STATUS: begin
                rdata[ST_BUSY]  = (state_q != S_IDLE);
                rdata[ST_EMPTY] = fifo_empty;
                rdata[ST_FULL]  = fifo_full;
                rdata[ST_OVF]   = ovf_q;
                rdata[ST_UNR]   = unr_q;
                rdata[ST_LEVEL_LSB +: 8] = 8'(fifo_level);
            end
            ADR_IDLE:  rdata = 32'(idle_q);
            ADR_TXCNT: rdata = txcnt_q;
            default:   rdata = '0;
        endcase
    end

    assign wb.DAT_O = rd ? rdata : 32'h0;

    assign fifo_push  = wr && (adr == ADR_TXDATA);
    assign fifo_flush = wr && (adr == ADR_CTRL) && wb.DAT_I[CTRL_FLUSH];

    wb_ser_fifo #(.DEPTH(FIFO_DEPTH), .T(frame_t)) u_fifo (
        .clk     (CLK_I),
        .rst     (RST_I),
        .push    (fifo_push),
        .wr_data (wb.DAT_I[26:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .flush   (fifo_flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign fifo_pop  = (state_q == S_IDLE) && enable_q && !fifo_empty;
    assign load_idle = (state_q == S_IDLE) && enable_q && fifo_empty && idle_fill_q;
    // is_data_q is cleared when underrun fires, so a drained queue flags it only once.
    assign underrun_evt = (state_q == S_IDLE) && enable_q && !idle_fill_q && fifo_empty && is_data_q;
    assign done_cnt     = (state_q == S_WAIT) && ser_done_i && is_data_q;

    always_comb begin
        enable_d    = enable_q;
        idle_fill_d = idle_fill_q;
        irq_en_d    = irq_en_q;
        low_wm_d    = low_wm_q;
        idle_d      = idle_q;
        txcnt_d     = txcnt_q;
        ovf_d       = ovf_q;
        unr_d       = unr_q;
        if (wr && adr == ADR_CTRL) begin
            enable_d    = wb.DAT_I[CTRL_EN];
            idle_fill_d = wb.DAT_I[CTRL_IDLE_FILL];
            irq_en_d    = wb.DAT_I[CTRL_IRQ_EN];
            low_wm_d    = wb.DAT_I[CTRL_LOW_WM_LSB +: 8];
        end
        if (wr && adr == ADR_IDLE) idle_d = wb.DAT_I[26:0];
        if (wr && adr == ADR_TXCNT) txcnt_d = '0;
        else if (done_cnt)          txcnt_d = txcnt_q + 32'd1;
        if (wr && adr == ADR_CLR && wb.DAT_I[ST_OVF]) ovf_d = 1'b0;
        if (wr && adr == ADR_CLR && wb.DAT_I[ST_UNR]) unr_d = 1'b0;
        if (fifo_push && fifo_full) ovf_d = 1'b1;
        if (underrun_evt)           unr_d = 1'b1;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            enable_q    <= 1'b0;
            idle_fill_q <= 1'b0;
            irq_en_q    <= 1'b0;
            low_wm_q    <= '0;
            idle_q      <= IDLE_RST;
            txcnt_q     <= '0;
            ovf_q       <= 1'b0;
            unr_q       <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            idle_fill_q <= idle_fill_d;
            irq_en_q    <= irq_en_d;
            low_wm_q    <= low_wm_d;
            idle_q      <= idle_d;
            txcnt_q     <= txcnt_d;
            ovf_q       <= ovf_d;
            unr_q       <= unr_d;
        end
    end

    // Scheduler; start_q is high exactly for the S_START cycle.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            is_data_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        frame_q   <= fifo_rd;
                        is_data_q <= 1'b1;
                        start_q   <= 1'b1;
                        state_q   <= S_START;
                    end else if (load_idle) begin
                        frame_q   <= idle_q;
                        is_data_q <= 1'b0;
                        start_q   <= 1'b1;
                        state_q   <= S_START;
                    end else if (underrun_evt) begin
                        is_data_q <= 1'b0;
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT:  if (ser_done_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ser_start_o = start_q;
    assign ser_data_o  = frame_q;
    assign irq_o       = irq_en_q && (9'(fifo_level) <= {1'b0, low_wm_q});
endmodule

// File: tb/tb_wb_serializer_sched.sv
// tb/tb_wb_serializer_sched.sv - scoreboard bench for wb_serializer_sched
module tb_wb_serializer_sched;
    logic        clk;
    logic        RST_I;
    logic        ser_start_o;
    logic [26:0] ser_data_o;
    logic        ser_done_i;
    logic        irq_o;
    logic        man_p, auto_p, auto_done, idle_ok;
    logic [26:0] idle_exp;

    int pass_cnt, total_cnt, start_cnt, cyc_cnt, ack_cyc, start_cyc;

    logic [26:0] exp_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    wb_serializer_sched_if wb();

    wb_serializer_sched #(.FIFO_DEPTH(8)) dut (
        .CLK_I       (clk),
        .RST_I       (RST_I),
        .wb          (wb),
        .ser_start_o (ser_start_o),
        .ser_data_o  (ser_data_o),
        .ser_done_i  (ser_done_i),
        .irq_o       (irq_o)
    );

    assign ser_done_i = man_p | auto_p;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Start monitor: every start must match the next queued data frame, or the idle frame
    // when nothing is queued and idle fill is expected.
    initial begin
        forever begin
            @(negedge clk);
            if (ser_start_o === 1'b1) begin
                start_cnt++;
                start_cyc = cyc_cnt;
                if (exp_q.size() > 0) chk("start_data", 32'(ser_data_o), 32'(exp_q.pop_front()));
                else if (idle_ok)     chk("start_idle", 32'(ser_data_o), 32'(idle_exp));
                else                  chk("unexpected_start", 32'(ser_start_o), 32'd0);
            end
        end
    end

    // Read monitor: compares DAT_O on every acked read.
    initial begin
        forever begin
            @(negedge clk);
            if (wb.CYC_I && wb.STB_I && !wb.WE_I && wb.ACK_O) begin
                if (rd_exp_q.size() > 0) chk(rd_name_q.pop_front(), wb.DAT_O, rd_exp_q.pop_front());
                else                     chk("unexpected_read", 32'(wb.ACK_O), 32'd0);
            end
        end
    end

    // Serializer model: done pulse a fixed delay after each start when enabled.
    initial begin
        auto_p = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_done && ser_start_o) begin
                repeat (5) @(posedge clk);
                #1 auto_p = 1'b1;
                @(posedge clk);
                #1 auto_p = 1'b0;
            end
        end
    end

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] data, input bit exp_err);
        @(posedge clk); #1;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b1;
        wb.ADR_I = 32'(adr); wb.DAT_I = data;
        @(negedge clk);
        ack_cyc = cyc_cnt;
        chk("wr_ack", 32'(wb.ACK_O), 32'(!exp_err));
        chk("wr_err", 32'(wb.ERR_O), 32'(exp_err));
        @(posedge clk); #1;
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    endtask

    task automatic push(input logic [26:0] f, input bit expect_sent);
        if (expect_sent) exp_q.push_back(f);
        wb_write(3'd1, 32'(f), 1'b0);
    endtask

    task automatic wb_read(input string name, input logic [2:0] adr, input logic [31:0] exp, input bit exp_err);
        @(posedge clk); #1;
        if (!exp_err) begin
            rd_exp_q.push_back(exp);
            rd_name_q.push_back(name);
        end
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0;
        wb.ADR_I = 32'(adr); wb.DAT_I = 32'h0;
        @(negedge clk);
        chk({name, "_ack"}, 32'(wb.ACK_O), 32'(!exp_err));
        chk({name, "_err"}, 32'(wb.ERR_O), 32'(exp_err));
        if (exp_err) chk({name, "_dat0"}, wb.DAT_O, 32'h0);
        @(posedge clk); #1;
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        int t;
        t = 0;
        while (start_cnt < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (start_cnt < n) chk("start_timeout", 32'(start_cnt), 32'(n));
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 man_p = 1'b1;
        @(posedge clk); #1 man_p = 1'b0;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; start_cnt = 0; cyc_cnt = 0;
        man_p = 1'b0; auto_done = 1'b0; idle_ok = 1'b0;
        idle_exp = {3{9'h1BC}};
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = '0; wb.DAT_I = '0;
        RST_I = 1'b1;
        repeat (3) @(posedge clk);
        #1 RST_I = 1'b0;

        // 1: reset state
        @(negedge clk);
        chk("rst_start", 32'(ser_start_o), 32'd0);
        chk("rst_data", 32'(ser_data_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        wb_read("rst_status", 3'd2, 32'h0000_0002, 1'b0);
        wb_read("rst_idle", 3'd3, 32'h06F3_79BC, 1'b0);
        wb_read("rst_ctrl", 3'd0, 32'h0, 1'b0);
        wb_read("rst_txcnt", 3'd4, 32'h0, 1'b0);

        // 2: single frame, latency, manual done
        wb_write(3'd0, 32'h1, 1'b0);
        push(27'h0123456, 1'b1);
        wait_starts(1, 20);
        chk("latency", 32'(start_cyc - ack_cyc), 32'd2);
        wb_read("busy_status", 3'd2, 32'h0000_0003, 1'b0);
        repeat (20) @(posedge clk);
        pulse_done();
        wb_read("t2_txcnt", 3'd4, 32'd1, 1'b0);
        wb_read("t2_status_unr", 3'd2, 32'h0000_0012, 1'b0);
        wb_write(3'd5, 32'h10, 1'b0);
        wb_read("t2_status_clr", 3'd2, 32'h0000_0002, 1'b0);

        // 3: overflow with enable off, then drain 8 in order
        wb_write(3'd0, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++) push(27'h5A5A000 + 27'(i * 17), i < 8);
        wb_read("t3_full", 3'd2, 32'h0008_000C, 1'b0);
        auto_done = 1'b1;
        wb_write(3'd0, 32'h1, 1'b0);
        wait_starts(9, 400);
        repeat (15) @(posedge clk);
        wb_read("t3_status", 3'd2, 32'h0000_001A, 1'b0);
        wb_write(3'd5, 32'h08, 1'b0);
        wb_read("t3_ovf_clr", 3'd2, 32'h0000_0012, 1'b0);
        wb_write(3'd5, 32'h10, 1'b0);
        wb_read("t3_unr_clr", 3'd2, 32'h0000_0002, 1'b0);
        wb_read("t3_txcnt", 3'd4, 32'd9, 1'b0);
        wb_write(3'd4, 32'hDEAD_BEEF, 1'b0);
        wb_read("t3_txcnt_clr", 3'd4, 32'd0, 1'b0);

        // flush with enable off
        wb_write(3'd0, 32'h0, 1'b0);
        push(27'h7000001, 1'b0);
        push(27'h7000002, 1'b0);
        wb_write(3'd0, 32'h8, 1'b0);
        wb_read("flush_status", 3'd2, 32'h0000_0002, 1'b0);
        wb_read("flush_ctrl", 3'd0, 32'h0, 1'b0);

        // 4: idle fill, data inserted mid-idle-frame
        idle_ok = 1'b1;
        wb_write(3'd0, 32'h3, 1'b0);
        wait_starts(start_cnt + 2, 60);
        wb_read("t4_txcnt0", 3'd4, 32'd0, 1'b0);
        wait_starts(start_cnt + 1, 30);
        push(27'h2ABCDEF, 1'b1);
        wait_starts(start_cnt + 3, 60);
        wb_read("t4_txcnt1", 3'd4, 32'd1, 1'b0);
        wb_write(3'd0, 32'h0, 1'b0);
        repeat (20) @(posedge clk);
        idle_ok = 1'b0;
        wb_read("t4_status", 3'd2, 32'h0000_0002, 1'b0);

        // 5: bus errors and irq watermark
        wb_read("rd_adr6", 3'd6, 32'h0, 1'b1);
        wb_read("rd_txdata", 3'd1, 32'h0, 1'b1);
        wb_read("rd_clr", 3'd5, 32'h0, 1'b1);
        wb_write(3'd2, 32'hFFFF_FFFF, 1'b1);
        wb_write(3'd7, 32'h0, 1'b1);
        push(27'h0000111, 1'b1);
        push(27'h0000222, 1'b1);
        push(27'h0000333, 1'b1);
        wb_write(3'd0, 32'h204, 1'b0);
        @(negedge clk);
        chk("irq_lvl3", 32'(irq_o), 32'd0);
        wb_write(3'd0, 32'h205, 1'b0);
        wait_starts(start_cnt + 1, 20);
        @(negedge clk);
        chk("irq_lvl2", 32'(irq_o), 32'd1);
        wait_starts(start_cnt + 2, 60);
        repeat (15) @(posedge clk);
        wb_write(3'd0, 32'h0, 1'b0);
        wb_write(3'd5, 32'h18, 1'b0);
        wb_read("t5_txcnt", 3'd4, 32'd4, 1'b0);
        @(negedge clk);
        chk("irq_off", 32'(irq_o), 32'd0);

        // 6: reset during S_WAIT with queued frames
        auto_done = 1'b0;
        wb_write(3'd0, 32'h1, 1'b0);
        push(27'h1111111, 1'b1);
        wait_starts(start_cnt + 1, 20);
        for (int i = 0; i < 4; i++) push(27'h3000000 + 27'(i), 1'b0);
        wb_read("t6_busy", 3'd2, 32'h0004_0001, 1'b0);
        @(posedge clk); #1 RST_I = 1'b1;
        @(posedge clk); #1 RST_I = 1'b0;
        @(negedge clk);
        chk("t6_start", 32'(ser_start_o), 32'd0);
        chk("t6_data", 32'(ser_data_o), 32'd0);
        wb_read("t6_status", 3'd2, 32'h0000_0002, 1'b0);
        pulse_done();
        wb_read("t6_txcnt", 3'd4, 32'd0, 1'b0);
        wb_read("t6_ctrl", 3'd0, 32'h0, 1'b0);
        repeat (10) @(posedge clk);

        chk("sb_frames_left", 32'(exp_q.size()), 32'd0);
        chk("sb_reads_left", 32'(rd_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc_cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_serializer_sched.md
Name: wb_serializer_sched

Overview:
Wishbone-slave scheduler that sequences the serializer datapath. Software pushes 27-bit frames (three 9-bit symbols {k, byte[7:0]}; k=1 marks a K-code) into a small FIFO. The block issues one start per frame to the serializer, waits for frame completion, then launches the next frame. When the FIFO is empty and idle-fill is enabled, it sends a programmable K-code idle frame to keep the link active. It sits between the Wishbone interconnect and one serializer instance.

Parameters:
FIFO_DEPTH, 8, number of frame entries; power of two, 2..256.
IDLE_RST, {3{9'h1BC}}, reset value of the IDLE register (three K28.5 commas).

Ports:
CLK_I  in  1  clock
RST_I  in  1  synchronous reset, active-high
CYC_I  in  1  Wishbone cycle
STB_I  in  1  Wishbone strobe
WE_I  in  1  Wishbone write enable
ADR_I  in  32  address; only ADR_I[2:0] decoded
DAT_I  in  32  write data
ACK_O  out  1  acknowledge (combinational)
ERR_O  out  1  error (combinational)
DAT_O  out  32  read data (combinational)
ser_start_o  out  1  one-cycle start pulse to the serializer
ser_data_o  out  27  frame for the serializer; held stable from start until done
ser_done_i  in  1  one-cycle pulse from the serializer when the last bit has been shifted out
irq_o  out  1  level: (FIFO level <= LOW_WM) && irq_en

Behaviour:
- Register map (ADR_I[2:0]):
  - 0 CTRL RW: b0 enable, b1 idle_fill, b2 irq_en, b3 flush (write-1, self-clears, reads 0), b[15:8] LOW_WM.
  - 1 TXDATA WO: push DAT_I[26:0].
  - 2 STATUS RO: b0 busy, b1 empty, b2 full, b3 overflow (sticky), b4 underrun (sticky), b[23:16] level.
  - 3 IDLE RW: idle frame, [26:0].
  - 4 TXCNT RW: count of FIFO frames sent, 32-bit, wraps; any write clears it.
  - 5 CLR WO: b3 clears overflow, b4 clears underrun.
- Wishbone: mapped access gives ACK_O = CYC_I&&STB_I in the same cycle and ERR_O=0. Unmapped address, or a read of a WO/write of a RO register, gives ERR_O = CYC_I&&STB_I and ACK_O=0. DAT_O=0 when not reading.
- Writes take effect on the clock edge of the acked cycle.
- Push when full: word dropped, overflow set, ACK_O still 1 (no ERR_O). A push while full is rejected even if a pop occurs in the same cycle.
- Reset values: all outputs 0 except DAT_O (0, combinational). CTRL=0, LOW_WM=0. IDLE=IDLE_RST. FIFO empty, counters 0, FSM in S_IDLE.
- FSM, states S_IDLE, S_START, S_WAIT:
  - S_IDLE: if enable && !empty, pop the FIFO into the frame register, set is_data, and go to S_START. Else if enable && idle_fill, load IDLE, clear is_data, and go to S_START. Else stay. If enable && !idle_fill && empty && the previous frame was data, set underrun once.
  - S_START: ser_start_o=1 for exactly one cycle, then go to S_WAIT.
  - S_WAIT: on ser_done_i, TXCNT += is_data, then go to S_IDLE. ser_done_i in any other state is ignored.
- busy = (state != S_IDLE).
- Latency: a TXDATA write acked in cycle N with the FIFO empty and the FSM in S_IDLE gives ser_start_o in cycle N+2. Back-to-back frames have a 2-cycle gap from ser_done_i to the next ser_start_o.
- ser_data_o is driven from the frame register and changes only on leaving S_IDLE.
- Clearing enable mid-frame: the in-flight frame completes, then the FSM stays in S_IDLE. Flush empties the FIFO in one cycle and does not abort the in-flight frame.
- FIFO pointers wrap modulo FIFO_DEPTH. Level runs 0..FIFO_DEPTH.
- Reset mid-frame returns everything to reset values on the next edge. No start is issued in the reset cycle.

Decomposition:
- Package WBSerSched holds:
  - address localparams ADR_CTRL..ADR_CLR;
  - the CTRL/STATUS bit-index localparams;
  - typedef enum logic [1:0] sched_state_t {S_IDLE, S_START, S_WAIT};
  - typedef logic [26:0] frame_t;
  - IDLE_DEFAULT.
- One sub-module, wb_ser_fifo: synchronous FIFO with push, pop, flush, full, empty and level outputs, parameterised by DEPTH and frame_t.

Test Plan:
1. Reset, then read STATUS and IDLE -> STATUS=32'h0000_0002, IDLE={3{9'h1BC}}, ser_start_o=0.
2. CTRL=1, push 27'h0123456 -> ser_start_o in cycle N+2 with ser_data_o=27'h0123456. ser_done_i 20 cycles later -> TXCNT=1, busy=0.
3. Push 9 words (DEPTH 8) with enable=0 -> full=1, overflow=1, level=8. Enable -> exactly 8 starts in order. Write CLR b3 -> overflow=0.
4. CTRL=3, FIFO empty -> repeated starts with ser_data_o={3{9'h1BC}} and TXCNT stays 0. A push mid-idle-frame is sent right after that frame's ser_done_i.
5. Read ADR 6 -> ERR_O=1, ACK_O=0. Write STATUS -> ERR_O=1. LOW_WM=2, irq_en=1, level 3->2 -> irq_o rises.
6. Assert RST_I during S_WAIT with 4 queued frames -> next cycle STATUS=2, ser_start_o stays 0, and a late ser_done_i leaves TXCNT at 0.
